// File: rtl/debounce_filter.sv
// Synchronizer plus counter-based stability filter for a bouncy asynchronous input.
// Optional macro DEBOUNCE_FILTER_PULSE_EN adds registered rise/fall strobes on qualified flips.
module debounce_filter #(
  parameter int   SYNC_STAGES     = 2,     // legal range 2..4
  parameter int   DEBOUNCE_CYCLES = 1000,  // minimum 1
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic busy
`ifdef DEBOUNCE_FILTER_PULSE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  typedef enum logic {
    IDLE,
    FILTER
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   busy_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the chain shift one stage per clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync_q != out_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            out_d = ~out_q;
          end else begin
            cnt_d   = CW'(1);
            state_d = FILTER;
          end
        end
      end
      FILTER: begin
        if (sync_q == out_q) begin
          // Any return to the current level throws away the partial qualification.
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          out_d   = sync_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= RESET_VALUE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= (state_d == FILTER);
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_FILTER_PULSE_EN
  logic rise_q, fall_q;

  // Strobes come from the same next-state decision that flips out, so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// Randomized and directed bench for debounce_filter against a run-length reference model.
// Honours DEBOUNCE_FILTER_PULSE_EN to also check the rise/fall strobes.
`timescale 1ns/1ps
module tb_debounce_filter;

  localparam int N = 3;

  function automatic int f_s(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  function automatic int f_d(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 5;
  endfunction

  function automatic logic f_rv(input int k);
    return (k == 1) ? 1'b1 : 1'b0;
  endfunction

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] din;
  wire  [N-1:0] dout;
  wire  [N-1:0] dbusy;
`ifdef DEBOUNCE_FILTER_PULSE_EN
  wire  [N-1:0] drise;
  wire  [N-1:0] dfall;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    debounce_filter #(
      .SYNC_STAGES    (f_s(g)),
      .DEBOUNCE_CYCLES(f_d(g)),
      .RESET_VALUE    (f_rv(g))
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .in   (din[g]),
      .out  (dout[g]),
      .busy (dbusy[g])
`ifdef DEBOUNCE_FILTER_PULSE_EN
      ,
      .rise (drise[g]),
      .fall (dfall[g])
`endif
    );
  end

  // Reference model: history of sampled inputs, and a run length of samples
  // (as seen after the synchronizer delay) that disagree with the modelled output.
  logic [7:0] hist [N];
  int         run  [N];
  logic       mout [N];
  logic       mrise[N];
  logic       mfall[N];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      hist[k]  = {8{f_rv(k)}};
      run[k]   = 0;
      mout[k]  = f_rv(k);
      mrise[k] = 1'b0;
      mfall[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic fin;
    for (int k = 0; k < N; k++) begin
      hist[k]  = {hist[k][6:0], din[k]};
      fin      = hist[k][f_s(k)];
      mrise[k] = 1'b0;
      mfall[k] = 1'b0;
      if (fin != mout[k]) begin
        run[k]++;
        if (run[k] == f_d(k)) begin
          mout[k] = ~mout[k];
          run[k]  = 0;
          if (mout[k]) mrise[k] = 1'b1;
          else         mfall[k] = 1'b1;
        end
      end else begin
        run[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      check($sformatf("out%0d@%0d", k, cyc), dout[k], mout[k]);
      check($sformatf("busy%0d@%0d", k, cyc), dbusy[k], (run[k] > 0));
`ifdef DEBOUNCE_FILTER_PULSE_EN
      check($sformatf("rise%0d@%0d", k, cyc), drise[k], mrise[k]);
      check($sformatf("fall%0d@%0d", k, cyc), dfall[k], mfall[k]);
`endif
    end
  endtask

  // One clock edge; inputs are only changed after this returns, i.e. 1ns past the edge.
  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic assert_reset_async();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
  endtask

  initial begin
    int t0;
    int e;
    int found;
    logic saw_busy;
    logic saw_out;
    int hold[N];

    din   = 3'b010;
    reset = 1'b1;
    model_reset();
    #12;
    check_all();
    check("reset_out0", dout[0], 1'b0);
    check("reset_out1", dout[1], 1'b1);

    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) step();

    // Clean step on u0 (0->1) and u1 (1->0, single-cycle qualification).
    din[0] = 1'b1;
    din[1] = 1'b0;
    t0 = cyc;
    repeat (8) begin
      step();
      e = cyc - t0;
      check($sformatf("clean_out0_e%0d", e), dout[0], (e >= 6));
      check($sformatf("clean_busy0_e%0d", e), dbusy[0], (e >= 3 && e <= 5));
      check($sformatf("clean_out1_e%0d", e), dout[1], (e < 3));
      check($sformatf("clean_busy1_e%0d", e), dbusy[1], 1'b0);
    end

    // Clean fall on u0, clean rise back on u1.
    din[0] = 1'b0;
    din[1] = 1'b1;
    t0 = cyc;
    repeat (8) begin
      step();
      e = cyc - t0;
      check($sformatf("fall_out0_e%0d", e), dout[0], (e < 6));
`ifdef DEBOUNCE_FILTER_PULSE_EN
      check($sformatf("fall_pulse0_e%0d", e), dfall[0], (e == 6));
`endif
    end

    // Glitch: three cycles high is too short for four-cycle qualification.
    saw_busy = 1'b0;
    saw_out  = 1'b0;
    din[0] = 1'b1;
    repeat (3) begin
      step();
      saw_busy |= dbusy[0];
      saw_out  |= dout[0];
    end
    din[0] = 1'b0;
    repeat (8) begin
      step();
      saw_busy |= dbusy[0];
      saw_out  |= dout[0];
    end
    check("glitch_busy_seen", saw_busy, 1'b1);
    check("glitch_out_stays0", saw_out, 1'b0);
    check("glitch_busy_ends", dbusy[0], 1'b0);

    // Bounce pattern 1,1,0,1,1,1,1 then held: rise 6 edges after the last 0->1.
    begin
      logic [6:0] pat;
      pat = 7'b1111011;
      t0 = 0;
      for (int i = 0; i < 7; i++) begin
        din[0] = pat[i];
        if (i == 3) t0 = cyc;
        if (dout[0]) break;
        step();
      end
    end
    found = -1;
    for (int i = 0; i < 20 && found < 0; i++) begin
      if (dout[0]) found = cyc - t0;
      else step();
    end
    if (found < 0) found = cyc - t0;
    check("bounce_latency", found, 6);

    // Toggling every cycle never qualifies.
    for (int i = 0; i < 20; i++) begin
      din[0] = i[0];
      din[2] = ~i[0];
      step();
      check($sformatf("toggle_out0_%0d", i), dout[0], 1'b1);
    end
    din[0] = 1'b0;
    din[2] = 1'b0;
    repeat (8) step();
    check("settle_out0", dout[0], 1'b0);

    // Reset in the middle of a qualification.
    din[0] = 1'b1;
    repeat (4) step();
    check("midfilter_busy0", dbusy[0], 1'b1);
    assert_reset_async();
    check("midreset_out0", dout[0], 1'b0);
    check("midreset_busy0", dbusy[0], 1'b0);
    step();
    reset = 1'b0;
    t0 = cyc;
    found = -1;
    for (int i = 0; i < 20 && found < 0; i++) begin
      step();
      if (dout[0]) found = cyc - t0;
    end
    check("postreset_latency", found, 6);

    // Randomized runs of random length on every instance.
    for (int k = 0; k < N; k++) hold[k] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) begin
        if (hold[k] == 0) begin
          din[k]  = $urandom_range(0, 1);
          hold[k] = $urandom_range(1, 8);
        end
        hold[k]--;
      end
      if (i == 300) begin
        assert_reset_async();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
